// File: rtl/inst_rom_loader_pkg.sv
// Shared types and helpers for the boot-loadable instruction ROM.
// Checksum support is enabled by defining LD_CHECKSUM_EN.
package inst_rom_loader_pkg;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        RomLoad  = 2'd0,
        RomRun   = 2'd1,
        RomCksum = 2'd2
    } rom_state_e;

    // Big-endian word from the held bytes plus the current byte; unfilled low bytes are zero.
    function automatic logic [31:0] pack_word(input logic [1:0]  idx,
                                              input logic [23:0] held,
                                              input logic [7:0]  b);
        logic [31:0] w;
        case (idx)
            2'd0:    w = {b, 24'h00_0000};
            2'd1:    w = {held[23:16], b, 16'h0000};
            2'd2:    w = {held[23:8], b, 8'h00};
            default: w = {held, b};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/inst_rom_loader_ld_word_pack.sv
// Byte-to-word packer for the boot-load port: holds bytes 0..2 and emits
// a write strobe with the full (or zero-filled final) word on byte 3 or last.
module ld_word_pack
    import inst_rom_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        xfer_i,
    input  logic [7:0]  byte_i,
    input  logic        last_i,
    output logic        wr_o,
    output logic [31:0] word_o
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] held_q, held_d;

    always_comb begin
        idx_d  = idx_q;
        held_d = held_q;
        wr_o   = 1'b0;
        word_o = pack_word(idx_q, held_q, byte_i);
        if (clr_i) begin
            idx_d = 2'd0;
        end else if (xfer_i) begin
            if (last_i || idx_q == 2'd3) begin
                wr_o  = 1'b1;
                idx_d = 2'd0;
            end else begin
                idx_d = idx_q + 2'd1;
                case (idx_q)
                    2'd0:    held_d[23:16] = byte_i;
                    2'd1:    held_d[15:8]  = byte_i;
                    default: held_d[7:0]   = byte_i;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= 2'd0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // Held bytes need no reset: a zero index makes stale contents invisible.
    always_ff @(posedge clk) begin
        held_q <= held_d;
    end

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory with byte-serial boot loader; holds the core in reset while loading.
// Optional image checksum stage enabled by defining LD_CHECKSUM_EN.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter bit BOOT_ON_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [31:0]       rom_addr_i,
    output logic [31:0]       rom_data_o,
    input  logic              ld_start_i,
    input  logic              ld_valid_i,
    input  logic [7:0]        ld_byte_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    output logic              core_rst_o,
    output logic              load_done_o,
    output logic [ADDR_W:0]   word_cnt_o,
`ifdef LD_CHECKSUM_EN
    output logic              cksum_err_o,
`endif
    output logic              ovf_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PTR_FULL = {1'b1, {ADDR_W{1'b0}}};

    rom_state_e       state_q, state_d;
    logic [ADDR_W:0]  ptr_q, ptr_d;
    logic             ovf_q, ovf_d;
    logic             core_rst_q, core_rst_d;
    logic             load_done_q, load_done_d;
    logic             mem_we;
    logic             xfer;
    logic             pk_clr, pk_xfer, pk_wr;
    logic [31:0]      pk_word;
    logic [31:0]      mem_q [DEPTH];
    logic             unused_addr_bits;

`ifdef LD_CHECKSUM_EN
    logic [7:0]       sum_q, sum_d;
    logic             err_q, err_d;
`endif

    assign xfer    = ld_valid_i & ld_ready_o;
    assign pk_xfer = xfer & (state_q == RomLoad);

    ld_word_pack u_pack (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (pk_clr),
        .xfer_i (pk_xfer),
        .byte_i (ld_byte_i),
        .last_i (ld_last_i),
        .wr_o   (pk_wr),
        .word_o (pk_word)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ovf_d   = ovf_q;
        pk_clr  = 1'b0;
        mem_we  = 1'b0;
`ifdef LD_CHECKSUM_EN
        sum_d   = sum_q;
        err_d   = err_q;
`endif
        case (state_q)
            RomRun: begin
                if (ld_start_i) begin
                    state_d = RomLoad;
                    ptr_d   = '0;
                    ovf_d   = 1'b0;
                    pk_clr  = 1'b1;
`ifdef LD_CHECKSUM_EN
                    sum_d   = 8'h00;
`endif
                end
            end
            RomLoad: begin
                // Past the top of the array words are dropped but bytes keep flowing until last.
                if (pk_wr) begin
                    if (ptr_q == PTR_FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                        ptr_d  = ptr_q + 1'b1;
                    end
                end
`ifdef LD_CHECKSUM_EN
                if (xfer) sum_d = sum_q + ld_byte_i;
                if (xfer && ld_last_i) state_d = RomCksum;
`else
                if (xfer && ld_last_i) state_d = RomRun;
`endif
            end
`ifdef LD_CHECKSUM_EN
            RomCksum: begin
                if (xfer) begin
                    if (ld_byte_i == 8'(8'h00 - sum_q)) begin
                        state_d = RomRun;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RomLoad;
                        ptr_d   = '0;
                        pk_clr  = 1'b1;
                        sum_d   = 8'h00;
                    end
                end
            end
`endif
            default: state_d = RomRun;
        endcase
        core_rst_d  = (state_d != RomRun);
        load_done_d = (state_d == RomRun);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BOOT_ON_RST ? RomLoad : RomRun;
            ptr_q       <= '0;
            ovf_q       <= 1'b0;
            core_rst_q  <= BOOT_ON_RST;
            load_done_q <= !BOOT_ON_RST;
`ifdef LD_CHECKSUM_EN
            sum_q       <= 8'h00;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ovf_q       <= ovf_d;
            core_rst_q  <= core_rst_d;
            load_done_q <= load_done_d;
`ifdef LD_CHECKSUM_EN
            sum_q       <= sum_d;
            err_q       <= err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[ptr_q[ADDR_W-1:0]] <= pk_word;
    end

    // Fetch sees only NOPs unless running, so the write port never competes with a read.
    always_comb begin
        rom_data_o = ZERO_WORD;
        if (rom_ce_i && state_q == RomRun) rom_data_o = mem_q[rom_addr_i[ADDR_W+1:2]];
    end

    assign unused_addr_bits = ^{rom_addr_i[31:ADDR_W+2], rom_addr_i[1:0]};

    assign ld_ready_o  = !rst && (state_q != RomRun);
    assign core_rst_o  = core_rst_q;
    assign load_done_o = load_done_q;
    assign word_cnt_o  = ptr_q;
    assign ovf_o       = ovf_q;
`ifdef LD_CHECKSUM_EN
    assign cksum_err_o = err_q;
`endif

endmodule
